// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: initialises registers, streams a program into instruction memory, runs the core, dumps registers
module mips32_prog_loader #(
  parameter int DATA_W    = 32,
  parameter int MEM_AW    = 10,
  parameter int REG_AW    = 5,
  parameter int NUM_REGS  = 32,
  parameter int INIT_REGS = 1,
  parameter int MAX_RUN   = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [MEM_AW:0]   prog_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              cpu_reset,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [REG_AW-1:0] d_idx,
  output logic [DATA_W-1:0] d_data,
  output logic              busy,
  output logic              done,
  output logic              timeout
);
  localparam int RW = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
  typedef enum logic [2:0] {IDLE, INIT, LOAD, RUN, DUMP, DONE} state_t;
  state_t state, nxt;
  logic [REG_AW-1:0] k;
  logic [MEM_AW:0] load_cnt, len;
  logic [RW-1:0] run_cnt;
  logic go, last_k, last_load, run_end;
  always_comb begin
    go = (state == IDLE || state == DONE) && start && prog_len != '0;
    last_k = k == REG_AW'(NUM_REGS - 1);
    last_load = s_valid && load_cnt == len - (MEM_AW+1)'(1);
    run_end = cpu_halted || run_cnt == RW'(MAX_RUN - 1);
    nxt = state;
    case (state)
      IDLE, DONE: nxt = go ? (INIT_REGS != 0 ? INIT : LOAD) : state;
      INIT:       nxt = last_k ? LOAD : INIT;
      LOAD:       nxt = last_load ? RUN : LOAD;
      RUN:        nxt = run_end ? DUMP : RUN;
      DUMP:       nxt = (d_ready && last_k) ? DONE : DUMP;
      default:    nxt = IDLE;
    endcase
  end
  // k walks the register file twice: writing Rk=k in INIT, reading for the dump in DUMP
  always_ff @(posedge clk1) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      load_cnt <= '0;
      run_cnt <= '0;
      len <= '0;
      timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (go) begin
        len <= prog_len;
        k <= '0;
        load_cnt <= '0;
        run_cnt <= '0;
        timeout <= 1'b0;
      end
      if (state == INIT || (state == DUMP && d_ready)) k <= last_k ? '0 : k + REG_AW'(1);
      if (state == LOAD && s_valid) load_cnt <= load_cnt + (MEM_AW+1)'(1);
      if (state == RUN) run_cnt <= run_cnt + RW'(1);
      if (state == RUN && run_end) timeout <= !cpu_halted;
    end
  end
  always_comb begin
    s_ready = state == LOAD;
    mem_we = s_ready && s_valid;
    mem_addr = s_ready ? load_cnt[MEM_AW-1:0] : '0;
    mem_wdata = s_ready ? s_data : '0;
    reg_we = state == INIT;
    d_valid = state == DUMP;
    reg_addr = (reg_we || d_valid) ? k : '0;
    reg_wdata = reg_we ? DATA_W'(k) : '0;
    d_idx = d_valid ? k : '0;
    d_data = d_valid ? reg_rdata : '0;
    cpu_run = state == RUN;
    cpu_reset = !(cpu_run || d_valid);
    busy = !(state == IDLE || state == DONE);
    done = state == DONE;
  end
endmodule
